// File: rtl/vga_prefetch.sv
`default_nettype none
// ============================================================================
// vga_prefetch : two-bank frame-buffer word prefetcher feeding the VGA display
// Revision     : 1.0
// ============================================================================
module vga_prefetch #(
  parameter int LOG_MEM     = 36,
  parameter int LOG_ADDR    = 19,
  parameter int FRAME_WORDS = 153600,
  parameter int MEM_LATENCY = 2,
  parameter int DEPTH       = 4
) (
  input  logic                clock,
  input  logic                reset_b,
  input  logic                frame_flag,
  input  logic                vga_flag,
  output logic [LOG_MEM-1:0]  vga_pixel,
  output logic                done_vga,
  output logic                mem_req,
  output logic [LOG_ADDR-1:0] mem_addr,
  input  logic                mem_grant,
  input  logic [LOG_MEM-1:0]  mem_read_data,
  output logic                underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + MEM_LATENCY + 1);
  localparam int IDX_W = LOG_ADDR - 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CUSHION   = CNT_W'(2);
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   armed_q, armed_d;
  logic                   bank_q, bank_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [MEM_LATENCY-1:0] inflight_q, inflight_d;
  logic                   mem_req_q, mem_req_d;
  logic                   done_q, done_d;
  logic                   underflow_q, underflow_d;
  logic [LOG_MEM-1:0]     storage_q [DEPTH];

  logic                   issue;
  logic                   push;
  logic                   pop;
  logic                   wr_en;
  logic [SUM_W-1:0]       outstanding;

  always_comb begin
    issue       = mem_req_q & mem_grant;
    push        = inflight_q[MEM_LATENCY-1];
    pop         = vga_flag & done_q;
    wr_en       = 1'b0;
    armed_d     = 1'b1;
    state_d     = state_q;
    bank_d      = bank_q;
    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    underflow_d = underflow_q | (vga_flag & ~done_q);

    if (frame_flag) begin
      // Flush: anything issued, returning or popped this cycle is dropped.
      bank_d     = ~bank_q;
      idx_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
      state_d    = FILL;
    end else begin
      if (issue) begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      inflight_d[0] = issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        inflight_d[i] = inflight_q[i-1];
      end
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (state_q == FILL && count_d == FULL_CNT) begin
        state_d = STREAM;
      end
    end

    // Requests are reserved against FIFO space so returns can never overflow it.
    outstanding = SUM_W'(count_d);
    for (int i = 0; i < MEM_LATENCY; i++) begin
      outstanding = outstanding + SUM_W'(inflight_d[i]);
    end
    mem_req_d = armed_q & ~frame_flag & (outstanding < DEPTH_SUM);
    done_d    = (state_d == STREAM) ? (count_d != '0) : (count_d >= CUSHION);
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= FILL;
      armed_q     <= 1'b0;
      bank_q      <= 1'b0;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        storage_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      bank_q      <= bank_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      mem_req_q   <= mem_req_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
      if (wr_en) begin
        storage_q[wr_ptr_q] <= mem_read_data;
      end
    end
  end

  assign vga_pixel = storage_q[rd_ptr_q];
  assign done_vga  = done_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = {bank_q, idx_q};
  assign underflow = underflow_q;

endmodule
`default_nettype wire
